// File: rtl/uart_rx_tx.sv
// 8N1 UART transmitter and receiver sharing one clock.
// TX and RX are independent FSMs; all outputs come straight from flops.
module uart_rx_tx #(
  parameter int unsigned CLKS_PER_BIT = 87
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_data_valid,
  input  logic [7:0] transmit_byte,
  output logic       tx_active,
  output logic       tx_serial,
  output logic       transmit_done,
  input  logic       rx_serial,
  output logic       rx_data_valid,
  output logic [7:0] received_byte
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_END = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] MID = CW'((CLKS_PER_BIT - 1) / 2);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP, S_CLEANUP
  } st_e;

  st_e           tx_st_q;
  logic [CW-1:0] tx_cnt_q;
  logic [2:0]    tx_idx_q;
  logic [7:0]    tx_byte_q;
  logic          tx_ser_q;
  logic          tx_act_q;
  logic          tx_done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_st_q   <= S_IDLE;
      tx_cnt_q  <= '0;
      tx_idx_q  <= '0;
      tx_byte_q <= '0;
      tx_ser_q  <= 1'b1;
      tx_act_q  <= 1'b0;
      tx_done_q <= 1'b0;
    end else begin
      unique case (tx_st_q)
        S_IDLE: begin
          tx_ser_q  <= 1'b1;
          tx_act_q  <= 1'b0;
          tx_done_q <= 1'b0;
          tx_cnt_q  <= '0;
          tx_idx_q  <= '0;
          if (tx_data_valid) begin
            tx_byte_q <= transmit_byte;
            tx_act_q  <= 1'b1;
            tx_ser_q  <= 1'b0;
            tx_st_q   <= S_START;
          end
        end
        S_START: begin
          if (tx_cnt_q == BIT_END) begin
            tx_cnt_q <= '0;
            tx_ser_q <= tx_byte_q[0];
            tx_st_q  <= S_DATA;
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        S_DATA: begin
          if (tx_cnt_q == BIT_END) begin
            tx_cnt_q <= '0;
            if (tx_idx_q == 3'd7) begin
              tx_ser_q <= 1'b1;
              tx_st_q  <= S_STOP;
            end else begin
              tx_idx_q <= tx_idx_q + 3'd1;
              tx_ser_q <= tx_byte_q[tx_idx_q + 3'd1];
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        S_STOP: begin
          if (tx_cnt_q == BIT_END) begin
            tx_cnt_q  <= '0;
            tx_act_q  <= 1'b0;
            tx_done_q <= 1'b1;
            tx_st_q   <= S_CLEANUP;
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        S_CLEANUP: begin
          tx_done_q <= 1'b0;
          tx_st_q   <= S_IDLE;
        end
        default: tx_st_q <= S_IDLE;
      endcase
    end
  end

  assign tx_serial     = tx_ser_q;
  assign tx_active     = tx_act_q;
  assign transmit_done = tx_done_q;

  logic [1:0] rx_sync_q;
  logic       rx_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_sync_q <= 2'b11;
    else        rx_sync_q <= {rx_sync_q[0], rx_serial};
  end

  assign rx_s = rx_sync_q[1];

  st_e           rx_st_q;
  logic [CW-1:0] rx_cnt_q;
  logic [2:0]    rx_idx_q;
  logic [7:0]    rx_shift_q;
  logic [7:0]    rx_byte_q;
  logic          rx_dv_q;

  // Sampling is offset half a bit from the start edge so every later
  // sample lands mid-bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_st_q    <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_shift_q <= '0;
      rx_byte_q  <= '0;
      rx_dv_q    <= 1'b0;
    end else begin
      unique case (rx_st_q)
        S_IDLE: begin
          rx_dv_q  <= 1'b0;
          rx_cnt_q <= '0;
          rx_idx_q <= '0;
          if (!rx_s) rx_st_q <= S_START;
        end
        S_START: begin
          if (rx_cnt_q == MID) begin
            rx_cnt_q <= '0;
            rx_st_q  <= rx_s ? S_IDLE : S_DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        S_DATA: begin
          if (rx_cnt_q == BIT_END) begin
            rx_cnt_q             <= '0;
            rx_shift_q[rx_idx_q] <= rx_s;
            if (rx_idx_q == 3'd7) rx_st_q <= S_STOP;
            else                  rx_idx_q <= rx_idx_q + 3'd1;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        S_STOP: begin
          if (rx_cnt_q == BIT_END) begin
            rx_cnt_q <= '0;
            rx_st_q  <= S_CLEANUP;
            if (rx_s) begin
              rx_byte_q <= rx_shift_q;
              rx_dv_q   <= 1'b1;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        S_CLEANUP: begin
          rx_dv_q <= 1'b0;
          rx_st_q <= S_IDLE;
        end
        default: rx_st_q <= S_IDLE;
      endcase
    end
  end

  assign rx_data_valid = rx_dv_q;
  assign received_byte = rx_byte_q;

endmodule

// File: tb/tb_uart_rx_tx.sv
// Randomized bench for uart_rx_tx against an 8N1 frame model.
// Covers TX timing, RX tolerance, glitches, framing errors and reset.
module tb_uart_rx_tx;

  localparam int CPB = 87;

  logic       clk;
  logic       rst_n;
  logic       tx_data_valid;
  logic [7:0] transmit_byte;
  logic       tx_active;
  logic       tx_serial;
  logic       transmit_done;
  logic       rx_line;
  logic       rx_data_valid;
  logic [7:0] received_byte;

  logic       rx_drv;
  logic       loop;
  logic [7:0] last_rx;
  logic [7:0] got[$];

  int checks = 0;
  int errors = 0;

  assign rx_line = loop ? tx_serial : rx_drv;

  uart_rx_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .tx_data_valid (tx_data_valid),
    .transmit_byte (transmit_byte),
    .tx_active     (tx_active),
    .tx_serial     (tx_serial),
    .transmit_done (transmit_done),
    .rx_serial     (rx_line),
    .rx_data_valid (rx_data_valid),
    .received_byte (received_byte)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (rx_data_valid === 1'b1) got.push_back(received_byte);

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Caller is at a negedge; returns at the negedge after CLEANUP.
  task automatic tx_frame(input logic [7:0] b, input bit inject);
    logic [9:0] fr;
    int bad[10];
    int bad_act;
    int bad_done;
    fr = {1'b1, b, 1'b0};
    foreach (bad[j]) bad[j] = 0;
    bad_act  = 0;
    bad_done = 0;
    tx_data_valid = 1'b1;
    transmit_byte = b;
    @(negedge clk);
    for (int i = 0; i < 10 * CPB; i++) begin
      if (tx_serial !== fr[i / CPB]) bad[i / CPB]++;
      if (tx_active !== 1'b1) bad_act++;
      if (transmit_done !== 1'b0) bad_done++;
      tx_data_valid = inject && (i == 300);
      transmit_byte = tx_data_valid ? 8'h12 : 8'($urandom);
      @(negedge clk);
    end
    for (int j = 0; j < 10; j++)
      chk($sformatf("tx %02h bit%0d", b, j), bad[j], 0);
    chk("tx active in frame", bad_act, 0);
    chk("tx done in frame", bad_done, 0);
    chk("tx done pulse", transmit_done, 1);
    chk("tx cleanup active", tx_active, 0);
    chk("tx cleanup line", tx_serial, 1);
    tx_data_valid = inject;
    transmit_byte = 8'h12;
    @(negedge clk);
    tx_data_valid = 1'b0;
    chk("tx done end", transmit_done, 0);
    chk("tx idle active", tx_active, 0);
  endtask

  task automatic rx_send(input logic [7:0] b, input int sl, input int bl,
                         input logic sv, input int stl);
    rx_drv = 1'b0;
    repeat (sl) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      rx_drv = b[k];
      repeat (bl) @(negedge clk);
    end
    rx_drv = sv;
    repeat (stl) @(negedge clk);
    rx_drv = 1'b1;
  endtask

  task automatic rx_expect(input string tag, input logic [7:0] b);
    chk({tag, " cnt"}, got.size(), 1);
    if (got.size() > 0) chk({tag, " byte"}, got[0], b);
    got.delete();
    last_rx = b;
  endtask

  initial begin
    logic [7:0] b;
    int sl;
    int bl;
    int bad;
    clk = 1'b0;
    rst_n = 1'b1;
    tx_data_valid = 1'b0;
    transmit_byte = 8'h00;
    rx_drv = 1'b1;
    loop = 1'b0;
    last_rx = 8'h00;
    #1 rst_n = 1'b0;
    #1;
    chk("rst tx_serial", tx_serial, 1);
    chk("rst tx_active", tx_active, 0);
    chk("rst done", transmit_done, 0);
    chk("rst rx_dv", rx_data_valid, 0);
    chk("rst rx_byte", received_byte, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    tx_frame(8'hAB, 1'b0);
    tx_frame(8'hAB, 1'b1);

    rx_send(8'h3F, 96, 86, 1'b1, 86);
    rx_expect("rx 3F", 8'h3F);
    repeat (10) @(negedge clk);

    rx_drv = 1'b0;
    repeat (20) @(negedge clk);
    rx_drv = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    chk("glitch cnt", got.size(), 0);
    chk("glitch byte", received_byte, last_rx);

    rx_send(8'($urandom), CPB, CPB, 1'b0, 55);
    repeat (2 * CPB) @(negedge clk);
    chk("frame err cnt", got.size(), 0);
    chk("frame err byte", received_byte, last_rx);
    got.delete();

    for (int n = 0; n < 6; n++) begin
      b  = 8'($urandom);
      sl = $urandom_range(104, 87);
      bl = $urandom_range(88, 86);
      rx_send(b, sl, bl, 1'b1, bl);
      rx_expect($sformatf("rx rand%0d", n), b);
      repeat ($urandom_range(20, 1)) @(negedge clk);
    end

    loop = 1'b1;
    @(negedge clk);
    tx_frame(8'h00, 1'b0);
    rx_expect("loop 00", 8'h00);
    tx_frame(8'hFF, 1'b0);
    rx_expect("loop FF", 8'hFF);
    tx_frame(8'h55, 1'b0);
    rx_expect("loop 55", 8'h55);
    for (int n = 0; n < 3; n++) begin
      b = 8'($urandom);
      tx_frame(b, 1'b0);
      rx_expect($sformatf("loop rand%0d", n), b);
    end

    b = 8'($urandom);
    tx_data_valid = 1'b1;
    transmit_byte = b;
    @(negedge clk);
    tx_data_valid = 1'b0;
    repeat (390) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid rst tx_serial", tx_serial, 1);
    chk("mid rst tx_active", tx_active, 0);
    chk("mid rst done", transmit_done, 0);
    chk("mid rst rx_dv", rx_data_valid, 0);
    chk("mid rst rx_byte", received_byte, 0);
    last_rx = 8'h00;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (transmit_done || rx_data_valid || tx_active) bad++;
    end
    rst_n = 1'b1;
    repeat (1000) begin
      @(negedge clk);
      if (transmit_done || rx_data_valid || tx_active) bad++;
    end
    chk("post rst no pulse", bad, 0);
    chk("post rst rx cnt", got.size(), 0);
    chk("post rst rx_byte", received_byte, last_rx);
    got.delete();
    tx_frame(8'hC3, 1'b0);
    rx_expect("loop C3", 8'hC3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
